// File: rtl/sram_rect_fill.sv
// sram_rect_fill
//   Write-side initiator for the framebuffer SRAM. It accepts a rectangle
//   command, clips it to the image, and issues one SRAM write per granted
//   cycle in row-major order.
// Ports
//   clk, reset     : posedge clock, synchronous active-high reset
//   start          : command strobe, sampled only while idle
//   x0, y0, w, h   : rectangle origin and size in pixels
//   colour         : fill value
//   grant          : SRAM port available this cycle
//   busy           : command in progress (SETUP, FILL, DONE)
//   done           : one-cycle completion pulse
//   sram_addr      : registered write address
//   sram_write     : write enable, FILL and grant
//   sram_data      : registered write data
module sram_rect_fill #(
  parameter int ADDR_WIDTH  = 14,
  parameter int DATA_WIDTH  = 12,
  parameter int IMG_W       = 300,
  parameter int IMG_H       = 54,
  parameter int COORD_WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [COORD_WIDTH-1:0] x0,
  input  logic [COORD_WIDTH-1:0] y0,
  input  logic [COORD_WIDTH-1:0] w,
  input  logic [COORD_WIDTH-1:0] h,
  input  logic [DATA_WIDTH-1:0]  colour,
  input  logic                   grant,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic                   sram_write,
  output logic [DATA_WIDTH-1:0]  sram_data
);

  localparam int XW = COORD_WIDTH + 1;
  localparam logic [XW-1:0]         IMG_W_X = XW'(IMG_W);
  localparam logic [XW-1:0]         IMG_H_X = XW'(IMG_H);
  localparam logic [ADDR_WIDTH-1:0] IMG_W_A = ADDR_WIDTH'(IMG_W);

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

  state_t state, state_next;

  logic [COORD_WIDTH-1:0] x0_q, y0_q, w_q, h_q;
  logic [DATA_WIDTH-1:0]  colour_q;
  logic [XW-1:0]          x_end, y_end, x, y;
  logic [ADDR_WIDTH-1:0]  row_base;

  logic [XW-1:0]          x_sum, y_sum, x_end_c, y_end_c;
  logic [ADDR_WIDTH-1:0]  row_base_c;
  logic                   empty, x_last, y_last;

  always_comb begin
    x_sum   = {1'b0, x0_q} + {1'b0, w_q};
    y_sum   = {1'b0, y0_q} + {1'b0, h_q};
    x_end_c = (x_sum > IMG_W_X) ? IMG_W_X : x_sum;
    y_end_c = (y_sum > IMG_H_X) ? IMG_H_X : y_sum;
    // Product may truncate for y0 beyond the image, but such commands are
    // empty and never use row_base.
    row_base_c = ADDR_WIDTH'(y0_q) * IMG_W_A;
    empty   = (w_q == '0) || (h_q == '0) ||
              ({1'b0, x0_q} >= IMG_W_X) || ({1'b0, y0_q} >= IMG_H_X);
    x_last  = (x == x_end - XW'(1));
    y_last  = (y == y_end - XW'(1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SETUP;
      SETUP:   state_next = empty ? DONE : FILL;
      FILL:    if (grant && x_last && y_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy       = (state != IDLE);
    done       = (state == DONE);
    sram_write = (state == FILL) && grant;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      x0_q      <= '0;
      y0_q      <= '0;
      w_q       <= '0;
      h_q       <= '0;
      colour_q  <= '0;
      x_end     <= '0;
      y_end     <= '0;
      x         <= '0;
      y         <= '0;
      row_base  <= '0;
      sram_addr <= '0;
      sram_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x0_q     <= x0;
            y0_q     <= y0;
            w_q      <= w;
            h_q      <= h;
            colour_q <= colour;
          end
        end
        SETUP: begin
          x_end     <= x_end_c;
          y_end     <= y_end_c;
          row_base  <= row_base_c;
          x         <= {1'b0, x0_q};
          y         <= {1'b0, y0_q};
          sram_data <= colour_q;
          if (!empty) sram_addr <= row_base_c + ADDR_WIDTH'(x0_q);
        end
        FILL: begin
          if (grant) begin
            // The final pixel leaves address/row untouched so the address
            // never steps past the last row.
            if (x_last && !y_last) begin
              x         <= {1'b0, x0_q};
              y         <= y + XW'(1);
              row_base  <= row_base + IMG_W_A;
              sram_addr <= row_base + IMG_W_A + ADDR_WIDTH'(x0_q);
            end else if (!x_last) begin
              x         <= x + XW'(1);
              sram_addr <= sram_addr + ADDR_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
